// File: rtl/seg7_display.sv
// Eight-digit multiplexed 7-segment driver for the calculator result.
// Decimal digits come from a sequential double-dabble, hex digits straight from the value.
`timescale 1ns/1ps
module seg7_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        CLK100MHZ,
  input  logic        RST,
  input  logic [15:0] value,
  input  logic        hex_mode,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [1:0]    r_state;
  logic [15:0]   r_shadow_val;
  logic          r_shadow_mode;
  logic [19:0]   r_bcd;
  logic [15:0]   r_shift;
  logic [3:0]    r_bit_cnt;
  logic [31:0]   r_digits;
  logic [7:0]    r_en;
  logic [RW-1:0] r_refresh;
  logic [2:0]    r_scan;

  logic          w_change;
  logic [19:0]   w_bcd_adj;
  logic [31:0]   w_raw;
  logic [7:0]    w_nz;
  logic [7:0]    w_en;
  logic [3:0]    w_cur_digit;
  logic          w_cur_en;
  logic [6:0]    w_pattern;

  assign w_change = (value != r_shadow_val) || (hex_mode != r_shadow_mode);
  assign DP       = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                                : r_bcd[gi*4 +: 4];
    end

    // Unused digit positions read as zero so the blanking chain ignores them.
    for (gi = 0; gi < 8; gi++) begin : g_digit
      if (gi < 4) begin : g_both
        assign w_raw[gi*4 +: 4] = r_shadow_mode ? r_shadow_val[gi*4 +: 4] : r_bcd[gi*4 +: 4];
      end else if (gi == 4) begin : g_dec
        assign w_raw[gi*4 +: 4] = r_shadow_mode ? 4'd0 : r_bcd[gi*4 +: 4];
      end else begin : g_none
        assign w_raw[gi*4 +: 4] = 4'd0;
      end
      assign w_nz[gi] = |w_raw[gi*4 +: 4];
      if (gi == 0) begin : g_lsd
        assign w_en[gi] = 1'b1;
      end else begin : g_upper
        assign w_en[gi] = |w_nz[7:gi];
      end
    end
  endgenerate

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_shadow_val  <= '0;
      r_shadow_mode <= 1'b0;
      r_bcd         <= '0;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_digits      <= '0;
      r_en          <= 8'h01;
      busy          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_change) begin
            r_shadow_val  <= value;
            r_shadow_mode <= hex_mode;
            r_bcd         <= '0;
            r_shift       <= value;
            r_bit_cnt     <= '0;
            busy          <= 1'b1;
            r_state       <= hex_mode ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
          r_bit_cnt        <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd15) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_digits <= w_raw;
          r_en     <= w_en;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_cur_digit = r_digits[{r_scan, 2'b00} +: 4];
  assign w_cur_en    = r_en[r_scan];

  always_comb begin
    w_pattern = 7'h7F;
    case (w_cur_digit)
      4'h0: w_pattern = 7'b1000000;
      4'h1: w_pattern = 7'b1111001;
      4'h2: w_pattern = 7'b0100100;
      4'h3: w_pattern = 7'b0110000;
      4'h4: w_pattern = 7'b0011001;
      4'h5: w_pattern = 7'b0010010;
      4'h6: w_pattern = 7'b0000010;
      4'h7: w_pattern = 7'b1111000;
      4'h8: w_pattern = 7'b0000000;
      4'h9: w_pattern = 7'b0010000;
      4'hA: w_pattern = 7'b0001000;
      4'hB: w_pattern = 7'b0000011;
      4'hC: w_pattern = 7'b1000110;
      4'hD: w_pattern = 7'b0100001;
      4'hE: w_pattern = 7'b0000110;
      4'hF: w_pattern = 7'b0001110;
      default: w_pattern = 7'h7F;
    endcase
  end

  // Outputs lag the scan index by one edge so they come straight from flops.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_refresh <= '0;
      r_scan    <= '0;
      AN        <= 8'hFF;
      SEG       <= 7'h7F;
    end else begin
      if (r_refresh == RW'(REFRESH_DIV - 1)) begin
        r_refresh <= '0;
        r_scan    <= r_scan + 3'd1;
      end else begin
        r_refresh <= r_refresh + RW'(1);
      end
      AN  <= w_cur_en ? ~(8'd1 << r_scan) : 8'hFF;
      SEG <= w_cur_en ? w_pattern : 7'h7F;
    end
  end

endmodule
